// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_LAT_W = 4;
  localparam int DMEM_BYTES = 4;

  // Value loaded into the wait counter so that WAIT lasts exactly `lat` cycles.
  function automatic logic [DMEM_LAT_W-1:0] lat_init(input int lat);
    return DMEM_LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word array with per-byte write enables and a registered, read-before-write read port.
import dmem_pkg::*;

module dmem_byte_array #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [AddrWidth-1:0]  idx,
  input  logic [DMEM_BYTES-1:0] we,
  input  logic [DataWidth-1:0]  wdata,
  output logic [DataWidth-1:0]  rd_data
);

  logic [DataWidth-1:0] mem [2**AddrWidth];

  // Contents are deliberately not reset; only stores change them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DMEM_BYTES; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_clr ? '0 : mem[idx];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency data-memory responder: IDLE -> WAIT (Latency cycles) -> RESP.
// Optional bounds checking with access_fault is enabled by DMEM_BOUNDS_CHECK_EN.
import dmem_pkg::*;

module data_memory_responder #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10,
  parameter int Latency   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic                  we_re,
  input  logic [3:0]            mask,
  input  logic [DataWidth-1:0]  address,
  input  logic [DataWidth-1:0]  store_data,
  output logic                  busy,
  output logic                  data_valid,
  output logic [DataWidth-1:0]  load_data,
  output logic [1:0]            state_dbg
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic                  access_fault
`endif
);

  // Handshake: a request is taken on any IDLE edge where request=1; the core
  // holds its inputs while busy=1, and the single data_valid pulse (one cycle,
  // no backpressure) completes the access for both loads and stores.

  dmem_state_e           state;
  logic [DMEM_LAT_W-1:0] cnt;
  logic                  hold_we;
  logic [3:0]            hold_mask;
  logic [AddrWidth-1:0]  hold_idx;
  logic [DataWidth-1:0]  hold_data;
  logic                  hold_oob;
  logic                  addr_oob;
  logic                  commit;
  logic [DMEM_BYTES-1:0] byte_we;
  logic                  unused_addr_bits;

  assign state_dbg = state;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign addr_oob         = |address[DataWidth-1:AddrWidth+2];
  assign unused_addr_bits = ^address[1:0];
`else
  assign addr_oob         = 1'b0;
  assign unused_addr_bits = ^{address[1:0], address[DataWidth-1:AddrWidth+2]};
`endif

  // Gating with rst keeps a reset on the commit edge from leaking a write.
  assign commit  = (state == WAIT) && (cnt == '0) && !rst;
  assign byte_we = (commit && hold_we && !hold_oob) ? hold_mask : '0;

  dmem_byte_array #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (commit),
    .rd_clr  (hold_oob),
    .idx     (hold_idx),
    .we      (byte_we),
    .wdata   (hold_data),
    .rd_data (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      hold_we    <= 1'b0;
      hold_mask  <= '0;
      hold_idx   <= '0;
      hold_data  <= '0;
      hold_oob   <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
      access_fault <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            hold_we   <= we_re;
            hold_mask <= mask;
            hold_idx  <= address[AddrWidth+1:2];
            hold_data <= store_data;
            hold_oob  <= addr_oob;
            cnt       <= lat_init(Latency);
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            data_valid <= 1'b1;
`ifdef DMEM_BOUNDS_CHECK_EN
            access_fault <= hold_oob;
`endif
            state <= RESP;
          end
        end
        RESP: begin
          data_valid <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
          access_fault <= 1'b0;
`endif
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy       <= 1'b0;
          data_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: vector table plus hand-written
// sequences for input changes during WAIT and reset during WAIT.
module tb_data_memory_responder;

  logic        clk;
  logic        rst;
  logic        request;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        busy;
  logic        data_valid;
  logic [31:0] load_data;
  logic [1:0]  state_dbg;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic        access_fault;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  data_memory_responder #(
    .DataWidth (32),
    .AddrWidth (10),
    .Latency   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .request    (request),
    .we_re      (we_re),
    .mask       (mask),
    .address    (address),
    .store_data (store_data),
    .busy       (busy),
    .data_valid (data_valid),
    .load_data  (load_data),
    .state_dbg  (state_dbg)
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    .access_fault (access_fault)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic fault_now();
`ifdef DMEM_BOUNDS_CHECK_EN
    return access_fault;
`else
    return 1'b0;
`endif
  endfunction

  // driver: one full access; returns response data, cycles to data_valid,
  // number of busy cycles seen and the fault flag during RESP
  task automatic access(input logic we, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int cycles, output int busy_cnt, output logic fault);
    @(negedge clk);
    request    = 1'b1;
    we_re      = we;
    mask       = m;
    address    = a;
    store_data = d;
    @(posedge clk);
    #1 request = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
    end while (!data_valid && cycles < 20);
    rd    = load_data;
    fault = fault_now();
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [31:0] rd;
    int          cyc;
    int          bc;
    logic        f;
    if (v.chk) exp_q.push_back(v.exp_rd);
    access(v.we, v.mask, v.addr, v.data, rd, cyc, bc, f);
    check($sformatf("v%0d_latency", n), cyc, 3);
    check($sformatf("v%0d_busy_cycles", n), bc, 3);
    check($sformatf("v%0d_fault", n), {31'd0, f}, {31'd0, v.exp_fault});
    if (v.chk) check($sformatf("v%0d_load_data", n), rd, exp_q.pop_front());
    @(negedge clk);
    check($sformatf("v%0d_single_pulse", n), {31'd0, data_valid}, 32'd0);
    check($sformatf("v%0d_idle_after", n), {29'd0, busy, state_dbg}, 32'd0);
  endtask

  task automatic load_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int          cyc;
    int          bc;
    logic        f;
    exp_q.push_back(exp);
    access(1'b0, 4'b1111, a, 32'h0, rd, cyc, bc, f);
    check({name, "_valid"}, {31'd0, data_valid}, 32'd1);
    check(name, rd, exp_q.pop_front());
  endtask

  initial begin
    int          cyc;
    int          seen;
    logic [31:0] rd;

    rst = 1'b1; request = 1'b0; we_re = 1'b0; mask = 4'b0;
    address = 32'h0; store_data = 32'h0;

    vecs.push_back('{1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00, 1'b1, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_ABEF, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'hDEAD_ABEF, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_ABEF, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_ABEF, 1'b0});
    vecs.push_back('{1'b1, 4'b1111, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 4'b1001, 32'h0000_0020, 32'h1122_3344, 1'b1, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_0020, 32'h0,         1'b1, 32'h11A5_A544, 1'b0});
`ifdef DMEM_BOUNDS_CHECK_EN
    vecs.push_back('{1'b1, 4'b1111, 32'h0000_1000, 32'h5555_5555, 1'b1, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_1000, 32'h0,         1'b1, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_1020, 32'h0,         1'b1, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_0020, 32'h0,         1'b1, 32'h11A5_A544, 1'b0});
`else
    // upper address bits are ignored, so 0x1020 aliases word 0x20
    vecs.push_back('{1'b1, 4'b0100, 32'h0000_1020, 32'hCAFE_F00D, 1'b1, 32'h11A5_A544, 1'b0});
    vecs.push_back('{1'b0, 4'b1111, 32'h0000_0020, 32'h0,         1'b1, 32'h11FE_A544, 1'b0});
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data_valid", {31'd0, data_valid}, 32'd0);
    check("reset_load_data", load_data, 32'h0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // inputs change during WAIT: only captured values may matter
    begin
      logic f;
      int   bc;
      access(1'b1, 4'b1111, 32'h0000_0040, 32'h0102_0304, rd, cyc, bc, f);
      @(negedge clk);
      request = 1'b1; we_re = 1'b1; mask = 4'b1111;
      address = 32'h0000_0040; store_data = 32'hAAAA_5555;
      @(posedge clk);
      #1;
      address = 32'h0000_0010; store_data = 32'hFFFF_FFFF; we_re = 1'b0; mask = 4'b0000;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        request = ~request;
      end while (!data_valid && cyc < 20);
      check("chg_latency", cyc, 3);
      check("chg_old_data", load_data, 32'h0102_0304);
      request = 1'b0;
      @(negedge clk);
      check("chg_no_reaccept", {31'd0, busy}, 32'd0);
      load_check("chg_new_word", 32'h0000_0040, 32'hAAAA_5555);
      load_check("chg_other_word", 32'h0000_0010, 32'hDEAD_ABEF);
    end

    // reset during the first WAIT cycle of a store
    @(negedge clk);
    request = 1'b1; we_re = 1'b1; mask = 4'b1111;
    address = 32'h0000_0040; store_data = 32'h7777_7777;
    @(posedge clk);
    #1 request = 1'b0;
    @(negedge clk);
    check("rst_in_wait_state", {30'd0, state_dbg}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_idle_next", {29'd0, busy, state_dbg}, 32'd0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (data_valid) seen++;
    end
    check("rst_no_response", seen, 0);
    load_check("rst_word_unchanged", 32'h0000_0040, 32'hAAAA_5555);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
